// File: rtl/id_ex_pipe_pkg.sv
// Shared constants for the ID->EX pipeline register: bubble instruction and
// the skid-buffer occupancy encoding.
package id_ex_pipe_pkg;

    localparam logic [31:0] INST_NOP = 32'h00000013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with valid/ready on both sides, registered
// in_ready and a synchronous flush that drops both entries.
module pipe_skid_buf
    import id_ex_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic         in_ready_q;
    logic         in_fire, out_fire;
    logic         load_main_in, load_main_skid, load_skid;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Any beat accepted this cycle is swallowed; out_fire still completes.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = FULL;
                        load_main_in = 1'b1;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d   = SKID;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_d        = FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register: skid-buffered handshake, flush bubble, NOP gating
// of the EX-side payload and a saturating stall counter.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter int               RA_W     = 5,
    parameter logic [XLEN-1:0]  NOP_INST = INST_NOP,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  inst_i,
    input  logic [XLEN-1:0]  inst_addr_i,
    input  logic [XLEN-1:0]  op1_i,
    input  logic [XLEN-1:0]  op2_i,
    input  logic [RA_W-1:0]  rd_addr_i,
    input  logic             reg_wen_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  inst_o,
    output logic [XLEN-1:0]  inst_addr_o,
    output logic [XLEN-1:0]  op1_o,
    output logic [XLEN-1:0]  op2_o,
    output logic [RA_W-1:0]  rd_addr_o,
    output logic             reg_wen_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int PW = 3*XLEN + XLEN + RA_W + 1;

    logic [PW-1:0]    pay_in, pay_out;
    logic [CNT_W-1:0] stall_cnt_q;

    assign pay_in = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};

    pipe_skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    // EX never sees stale payload: an empty stage looks like a NOP with wen low.
    always_comb begin
        inst_o      = NOP_INST;
        inst_addr_o = '0;
        op1_o       = '0;
        op2_o       = '0;
        rd_addr_o   = '0;
        reg_wen_o   = 1'b0;
        if (out_valid)
            {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o} = pay_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe (CNT_W=4 to reach saturation).
module tb_id_ex_pipe;
    import id_ex_pipe_pkg::*;

    localparam int XLEN = 32, RA_W = 5, CNT_W = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, reg_wen_i = 0, reg_wen_o;
    logic [XLEN-1:0] inst_i = 0, inst_addr_i = 0, op1_i = 0, op2_i = 0;
    logic [XLEN-1:0] inst_o, inst_addr_o, op1_o, op2_o;
    logic [RA_W-1:0] rd_addr_i = 0, rd_addr_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int errors = 0, checks = 0;

    id_ex_pipe #(.XLEN(XLEN), .RA_W(RA_W), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i), .out_valid(out_valid),
        .out_ready(out_ready), .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o),
        .op2_o(op2_o), .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst);
        in_valid    = v;
        inst_i      = inst;
        inst_addr_i = inst ^ 32'h0000_1000;
        op1_i       = inst + 32'd1;
        op2_i       = inst + 32'd2;
        rd_addr_i   = inst[11:7];
        reg_wen_i   = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; flush = 0; out_ready = 0; drive(1'b0, 32'h0);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", inst_o, NOP); end
        checks++; if ({inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o} !== '0) begin errors++; $display("FAIL reset_payload got nonzero exp 0"); end
        checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt_o); end
    endtask

    task automatic test_streaming();
        logic [31:0] seq [3];
        seq[0] = 32'h00500093; seq[1] = 32'h00600113; seq[2] = 32'h002081B3;
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, seq[i]);
            step();
            checks++; if (inst_o !== seq[i] || out_valid !== 1'b1) begin errors++; $display("FAIL stream_inst%0d got %h/%b exp %h/1", i, inst_o, out_valid, seq[i]); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b exp 1", i, in_ready); end
        end
        checks++; if (op1_o !== 32'h002081B4 || op2_o !== 32'h002081B5 || rd_addr_o !== 5'd3 || reg_wen_o !== 1'b1 || inst_addr_o !== 32'h002091B3)
            begin errors++; $display("FAIL stream_fields got %h %h %h %h %b", inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o); end
        drive(1'b0, 32'hDEADBEEF);
        step();
        checks++; if (out_valid !== 1'b0 || inst_o !== NOP || reg_wen_o !== 1'b0) begin errors++; $display("FAIL stream_drain got %b %h %b exp 0 %h 0", out_valid, inst_o, reg_wen_o, NOP); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 0;
        drive(1'b1, 32'hAAAA0001); step();
        drive(1'b1, 32'hBBBB0002); step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        checks++; if (inst_o !== 32'hAAAA0001) begin errors++; $display("FAIL bp_hold_a got %h exp aaaa0001", inst_o); end
        drive(1'b1, 32'hCCCC0003); step();
        checks++; if (inst_o !== 32'hAAAA0001 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_hold got %h/%b exp aaaa0001/0", inst_o, in_ready); end
        drive(1'b0, 32'h0);
        out_ready = 1; step();
        checks++; if (inst_o !== 32'hBBBB0002 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_then_b got %h/%b exp bbbb0002/1", inst_o, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
        checks++; if (stall_cnt_o !== 4'd2) begin errors++; $display("FAIL bp_stall_cnt got %0d exp 2", stall_cnt_o); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 0;
        drive(1'b1, 32'h11110001); step();
        drive(1'b1, 32'h22220002); step();
        drive(1'b0, 32'h0); step();
        checks++; if (in_ready !== 1'b0 || stall_cnt_o !== 4'd2) begin errors++; $display("FAIL midrst_pre got %b/%0d exp 0/2", in_ready, stall_cnt_o); end
        #2 rst = 1; #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_hs got %b/%b exp 0/1", out_valid, in_ready); end
        checks++; if (inst_o !== NOP || reg_wen_o !== 1'b0 || stall_cnt_o !== 4'd0) begin errors++; $display("FAIL midrst_out got %h/%b/%0d exp %h/0/0", inst_o, reg_wen_o, stall_cnt_o, NOP); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 0;
        drive(1'b1, 32'hAAAA0001); step();
        drive(1'b1, 32'hBBBB0002); step();
        drive(1'b1, 32'hEEEE0005); flush = 1; step();
        flush = 0; drive(1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0 || inst_o !== NOP || in_ready !== 1'b1) begin errors++; $display("FAIL flush_skid got %b/%h/%b exp 0/%h/1", out_valid, inst_o, in_ready, NOP); end
        checks++; if (stall_cnt_o !== 4'd2) begin errors++; $display("FAIL flush_keeps_cnt got %0d exp 2", stall_cnt_o); end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak%0d got %b %h exp 0", i, out_valid, inst_o); end
        end
        // In FULL, a beat accepted together with flush is dropped.
        drive(1'b1, 32'h12340001); step();
        drive(1'b1, 32'h12340002); flush = 1; step();
        flush = 0; drive(1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0 || inst_o !== NOP) begin errors++; $display("FAIL flush_full got %b/%h exp 0/%h", out_valid, inst_o, NOP); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1;
        drive(1'b1, 32'hAAAA0001); step();
        drive(1'b1, 32'hC0DE0C0C); step();
        checks++; if (inst_o !== 32'hC0DE0C0C || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b got %h/%b/%b exp c0de0c0c/1/1", inst_o, out_valid, in_ready); end
        drive(1'b0, 32'h0);
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 0;
        drive(1'b1, 32'h5A5A0001); step();
        drive(1'b0, 32'h0);
        repeat (20) step();
        checks++; if (stall_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", stall_cnt_o); end
        checks++; if (out_valid !== 1'b1 || inst_o !== 32'h5A5A0001) begin errors++; $display("FAIL sat_hold got %b/%h exp 1/5a5a0001", out_valid, inst_o); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        test_flush();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Parametrised ID→EX pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Supports downstream stall (backpressure) and a synchronous flush that inserts a bubble.
- Presents a NOP with write-enable low to EX whenever it holds no valid instruction.
- Sits between the decode and execute stages.
- Adds a saturating counter of stall cycles for performance monitoring.

Parameters:
- XLEN, 32, width of instruction, instruction address and operands.
- RA_W, 5, register-address width.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0); equals `INST_NOP.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset.
- flush  in  1  synchronous flush; branch/jump redirect from EX.
- in_valid  in  1  ID offers a beat.
- in_ready  out  1  stage accepts a beat; driven directly from a register.
- inst_i  in  XLEN  instruction.
- inst_addr_i  in  XLEN  instruction address.
- op1_i  in  XLEN  operand 1.
- op2_i  in  XLEN  operand 2.
- rd_addr_i  in  RA_W  destination register.
- reg_wen_i  in  1  register write enable.
- out_valid  out  1  EX-side beat valid.
- out_ready  in  1  EX accepts the beat.
- inst_o  out  XLEN  instruction to EX.
- inst_addr_o  out  XLEN  instruction address to EX.
- op1_o  out  XLEN  operand 1 to EX.
- op2_o  out  XLEN  operand 2 to EX.
- rd_addr_o  out  RA_W  destination register to EX.
- reg_wen_o  out  1  register write enable to EX.
- stall_cnt_o  out  CNT_W  count of backpressured cycles.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is asynchronous and active-high.
- Reset state:
  - State EMPTY.
  - in_ready=1, out_valid=0.
  - inst_o=NOP_INST; inst_addr_o, op1_o, op2_o, rd_addr_o = 0; reg_wen_o=0.
  - stall_cnt_o=0.
  - Skid contents are don't-care.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- State encoding:
  - EMPTY: main invalid, skid invalid.
  - FULL: main valid, skid invalid.
  - SKID: main valid, skid valid.
- Derived outputs:
  - out_valid = (state != EMPTY).
  - in_ready = (state != SKID), registered as next_state != SKID.
- Transitions when flush=0:
  - EMPTY, in_fire → FULL; main ← input.
  - FULL, in_fire & out_fire → FULL; main ← input.
  - FULL, in_fire & !out_fire → SKID; skid ← input; main held.
  - FULL, !in_fire & out_fire → EMPTY.
  - SKID, out_fire → FULL; main ← skid.
  - SKID, otherwise → SKID; everything held; in_ready=0.
  - Any other combination holds state and data.
- Flush:
  - flush=1 has highest priority over all handshakes.
  - Next state is EMPTY and both entries are invalidated.
  - A beat with in_fire in the same cycle is consumed and discarded.
  - Any out_fire in that cycle still completes.
- Output gating when out_valid=0:
  - inst_o=NOP_INST; other payload outputs 0; reg_wen_o=0.
  - Gating is combinational on the registered state.
- Timing:
  - Latency is 1 cycle from in_fire to out_valid when the stage is empty.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
- Ordering: strictly FIFO; main is always older than skid.
- Stall counter:
  - Increments when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst; flush does not clear it.
- X-safety: payload inputs are ignored when in_valid=0.

Decomposition:
- Shared defines:
  - INST_NOP.
  - State encodings: EMPTY=2'd0, FULL=2'd1, SKID=2'd2.
- One natural sub-module, pipe_skid_buf:
  - Generic 2-entry skid buffer, parameter W.
  - Ports: clk, rst, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
- id_ex_pipe responsibilities:
  - Packs fields into a payload of W = 3*XLEN+XLEN+RA_W+1 bits.
  - Applies the NOP/zero gating.
  - Owns the stall counter.

Test Plan:
- Reset mid-stream: assert rst asynchronously while in state SKID → same cycle: out_valid=0, in_ready=1, inst_o=32'h00000013, reg_wen_o=0, stall_cnt_o=0.
- Streaming: out_ready=1; feed inst 0x00500093/0x00600113/0x002081B3 on consecutive cycles → each appears on inst_o one cycle later; in_ready stays 1.
- Backpressure: out_ready=0; push A then B → after B, in_ready=0 and inst_o holds A. Raise out_ready → A, then B, in order; stall_cnt_o equals the stalled cycle count.
- Flush in SKID with in_valid=1 → next cycle out_valid=0, inst_o=NOP, in_ready=1; A, B and the incoming beat never reach EX.
- Simultaneous fire in FULL: in_fire & out_fire with C → main=C, state stays FULL, no bubble.
- Saturation: CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt_o=15.
